ifu_fetch: RTL and testbench

- Instruction fetch unit: the producer side of the instruction interface consumed by the decoder.
- Holds the PC and issues one word fetch at a time over a req/rsp memory handshake.
- Presents the fetched 32-bit instruction plus its PC to decode over a valid/ready handshake.
- Accepts PC redirects from execute (branch/jal/jalr/trap).
- Multi-cycle, one instruction in flight, single-entry output buffer.

---
 rtl/ifu_fetch.sv | 179 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: holds the PC, fetches one word at a time over req/rsp and presents it to decode; redirects take priority.
// Optional counters under YSYX_23060251_IFU_PERF_EN; 3 cycles per instruction minimum, single-entry output buffer.
module ifu_fetch #(
  parameter int unsigned          XLEN     = 64,
  parameter int unsigned          INST_W   = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              redirect_valid_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [XLEN-1:0]   req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [INST_W-1:0] rsp_data_i,
  input  logic              rsp_err_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              inst_err_o
`ifdef YSYX_23060251_IFU_PERF_EN
  ,
  output logic [XLEN-1:0]   perf_fetch_o,
  output logic [XLEN-1:0]   perf_wait_o
`endif
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]        state, nxt_state;
  logic [XLEN-1:0]   pc_q, nxt_pc;
  logic              drop_q, nxt_drop;
  logic              nxt_req_valid;
  logic [XLEN-1:0]   nxt_req_addr;
  logic              nxt_inst_valid;
  logic [INST_W-1:0] nxt_inst;
  logic [XLEN-1:0]   nxt_inst_pc;
  logic              nxt_inst_err;
  logic              enter;
  logic [XLEN-1:0]   enter_pc;

  always_comb begin
    nxt_state      = state;
    nxt_pc         = pc_q;
    nxt_drop       = drop_q;
    nxt_req_valid  = req_valid_o;
    nxt_req_addr   = req_addr_o;
    nxt_inst_valid = inst_valid_o;
    nxt_inst       = inst_o;
    nxt_inst_pc    = pc_o;
    nxt_inst_err   = inst_err_o;
    enter          = 1'b0;
    enter_pc       = pc_q;

    case (state)
      S_REQ: begin
        // req_valid_o low here only right after reset, before the first launch.
        if (redirect_valid_i) begin
          if (req_valid_o && req_ready_i) begin
            nxt_state     = S_WAIT;
            nxt_req_valid = 1'b0;
            nxt_drop      = 1'b1;
            nxt_pc        = redirect_pc_i;
          end else begin
            enter    = 1'b1;
            enter_pc = redirect_pc_i;
          end
        end else if (!req_valid_o) begin
          enter    = 1'b1;
          enter_pc = pc_q;
        end else if (req_ready_i) begin
          nxt_state     = S_WAIT;
          nxt_req_valid = 1'b0;
        end
      end

      S_WAIT: begin
        if (rsp_valid_i) begin
          if (redirect_valid_i) begin
            nxt_drop = 1'b0;
            enter    = 1'b1;
            enter_pc = redirect_pc_i;
          end else if (drop_q) begin
            nxt_drop = 1'b0;
            enter    = 1'b1;
            enter_pc = pc_q;
          end else begin
            nxt_state      = S_HOLD;
            nxt_inst_valid = 1'b1;
            nxt_inst       = rsp_err_i ? '0 : rsp_data_i;
            nxt_inst_err   = rsp_err_i;
            nxt_inst_pc    = pc_q;
          end
        end else if (redirect_valid_i) begin
          nxt_drop = 1'b1;
          nxt_pc   = redirect_pc_i;
        end
      end

      S_HOLD: begin
        if (redirect_valid_i) begin
          nxt_inst_valid = 1'b0;
          enter          = 1'b1;
          enter_pc       = redirect_pc_i;
        end else if (inst_ready_i) begin
          nxt_inst_valid = 1'b0;
          enter          = 1'b1;
          enter_pc       = pc_q + XLEN'(4);
        end
      end

      default: begin
        nxt_state = S_REQ;
      end
    endcase

    // Entering S_REQ: a misaligned PC skips memory and becomes a faulting instruction.
    if (enter) begin
      nxt_pc = enter_pc;
      if (enter_pc[1:0] != 2'b00) begin
        nxt_state      = S_HOLD;
        nxt_req_valid  = 1'b0;
        nxt_inst_valid = 1'b1;
        nxt_inst       = '0;
        nxt_inst_err   = 1'b1;
        nxt_inst_pc    = enter_pc;
      end else begin
        nxt_state      = S_REQ;
        nxt_req_valid  = 1'b1;
        nxt_req_addr   = enter_pc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      req_valid_o  <= 1'b0;
      req_addr_o   <= '0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      pc_o         <= '0;
      inst_err_o   <= 1'b0;
    end else begin
      state        <= nxt_state;
      pc_q         <= nxt_pc;
      drop_q       <= nxt_drop;
      req_valid_o  <= nxt_req_valid;
      req_addr_o   <= nxt_req_addr;
      inst_valid_o <= nxt_inst_valid;
      inst_o       <= nxt_inst;
      pc_o         <= nxt_inst_pc;
      inst_err_o   <= nxt_inst_err;
    end
  end

`ifdef YSYX_23060251_IFU_PERF_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_fetch_o <= '0;
      perf_wait_o  <= '0;
    end else begin
      if (inst_valid_o && inst_ready_i) begin
        perf_fetch_o <= perf_fetch_o + XLEN'(1);
      end
      if (state == S_WAIT) begin
        perf_wait_o <= perf_wait_o + XLEN'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: memory responder, next-PC reference model with per-cycle compare, directed scenarios.
module tb_ifu_fetch;
  localparam logic [63:0] RST_PC   = 64'h8000_0000;
  localparam logic [63:0] ERR_ADDR = 64'h8000_0200;

  logic        clk_i;
  logic        rst_n_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [63:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        inst_err_o;
`ifdef YSYX_23060251_IFU_PERF_EN
  logic [63:0] perf_fetch_o;
  logic [63:0] perf_wait_o;
`endif

  ifu_fetch dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .req_valid_o      (req_valid_o),
    .req_ready_i      (req_ready_i),
    .req_addr_o       (req_addr_o),
    .rsp_valid_i      (rsp_valid_i),
    .rsp_data_i       (rsp_data_i),
    .rsp_err_i        (rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .inst_err_o       (inst_err_o)
`ifdef YSYX_23060251_IFU_PERF_EN
    ,
    .perf_fetch_o     (perf_fetch_o),
    .perf_wait_o      (perf_wait_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_fetch = 0;
  int cyc = 0;
  int last_hs = -1;
  int hs_gap = 0;
  int rsp_delay = 0;
  logic [63:0] m_pc;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == RST_PC) return 32'h0010_0073;
    if (a == ERR_ADDR) return 32'hdead_beef;
    return a[31:0] ^ 32'h5a5a_0013;
  endfunction

  function automatic logic exp_err(input logic [63:0] a);
    return (a[1:0] != 2'b00) || (a == ERR_ADDR);
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] a);
    return exp_err(a) ? 32'h0 : mem_word(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Memory: accepts a request, answers after rsp_delay extra cycles.
  initial begin
    logic        pend;
    logic [63:0] paddr;
    int          cnt;
    pend = 1'b0; paddr = '0; cnt = 0;
    rsp_valid_i = 1'b0; rsp_data_i = '0; rsp_err_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && req_valid_o && req_ready_i) begin
        pend = 1'b1; paddr = req_addr_o; cnt = rsp_delay;
      end
      @(posedge clk_i);
      #1;
      rsp_valid_i = 1'b0;
      if (!rst_n_i) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          rsp_valid_i = 1'b1;
          rsp_data_i  = mem_word(paddr);
          rsp_err_i   = (paddr == ERR_ADDR);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Reference model: the PC decode must see next, advanced by 4 per consumed instruction, replaced by redirects.
  initial begin
    logic p_iv, p_ir, p_rd, p_rv, p_rr, p_err;
    logic [31:0] p_inst;
    logic [63:0] p_pc, p_addr;
    p_iv = 0; p_ir = 0; p_rd = 0; p_rv = 0; p_rr = 0; p_err = 0;
    p_inst = '0; p_pc = '0; p_addr = '0;
    m_pc = RST_PC;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_n_i) begin
        m_pc = RST_PC; p_iv = 0; p_rv = 0; last_hs = -1;
      end else begin
        if (p_iv && !p_ir && !p_rd) begin
          chk("hold_valid", inst_valid_o, 1);
          chk("hold_inst", inst_o, p_inst);
          chk("hold_pc", pc_o, p_pc);
          chk("hold_err", inst_err_o, p_err);
        end
        if (p_rv && !p_rr && !p_rd) begin
          chk("req_hold_valid", req_valid_o, 1);
          chk("req_hold_addr", req_addr_o, p_addr);
        end
        chk("one_in_flight", req_valid_o && inst_valid_o, 0);
        if (req_valid_o) chk("req_aligned", req_addr_o[1:0], 0);
        if (inst_valid_o && inst_ready_i) begin
          chk("inst_pc", pc_o, m_pc);
          chk("inst_word", inst_o, exp_inst(m_pc));
          chk("inst_err", inst_err_o, exp_err(m_pc));
          n_fetch++;
          if (last_hs >= 0) hs_gap = cyc - last_hs;
          last_hs = cyc;
          m_pc = m_pc + 64'd4;
        end
        if (req_valid_o && req_ready_i && !redirect_valid_i) chk("req_addr", req_addr_o, m_pc);
        if (redirect_valid_i) m_pc = redirect_pc_i;
        p_iv = inst_valid_o; p_ir = inst_ready_i; p_rd = redirect_valid_i;
        p_inst = inst_o; p_pc = pc_o; p_err = inst_err_o;
        p_rv = req_valid_o; p_rr = req_ready_i; p_addr = req_addr_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (!req_valid_o && k < 40) begin tick(); k++; end
    chk(nm, req_valid_o, 1);
  endtask

  task automatic wait_inst(input string nm);
    int k = 0;
    while (!inst_valid_o && k < 40) begin tick(); k++; end
    chk(nm, inst_valid_o, 1);
  endtask

  task automatic wait_fetches(input int n);
    int target = n_fetch + n;
    int k = 0;
    while (n_fetch < target && k < 300) begin tick(); k++; end
    chk("fetch_progress", n_fetch >= target, 1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_valid"}, req_valid_o, 0);
    chk({tag, "_req_addr"}, req_addr_o, 0);
    chk({tag, "_inst_valid"}, inst_valid_o, 0);
    chk({tag, "_inst"}, inst_o, 0);
    chk({tag, "_pc"}, pc_o, 0);
    chk({tag, "_err"}, inst_err_o, 0);
  endtask

  initial begin
    logic [31:0] h_inst;
    logic [63:0] h_pc;
    logic        req_seen;
    rst_n_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;
    req_ready_i = 1'b0; inst_ready_i = 1'b0;
    #1 rst_n_i = 1'b0;
    #20;
    chk_zero_outputs("reset");

    // Free-running fetch from the reset PC.
    @(posedge clk_i); #1;
    rst_n_i = 1'b1; req_ready_i = 1'b1; inst_ready_i = 1'b1;
    wait_req("first_req");
    chk("first_req_addr", req_addr_o, 64'h8000_0000);
    wait_inst("first_inst");
    chk("first_inst_word", inst_o, 32'h0010_0073);
    chk("first_inst_pc", pc_o, 64'h8000_0000);
    chk("first_inst_err", inst_err_o, 0);
    tick();
    wait_req("second_req");
    chk("second_req_addr", req_addr_o, 64'h8000_0004);
    wait_fetches(3);
    chk("cycles_per_inst", hs_gap, 3);

    // Decode stall for 5 cycles.
    inst_ready_i = 1'b0;
    wait_inst("stall_inst");
    h_inst = inst_o; h_pc = pc_o;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", inst_valid_o, 1);
      chk("stall_inst", inst_o, h_inst);
      chk("stall_pc", pc_o, h_pc);
      chk("stall_no_req", req_valid_o, 0);
    end
    inst_ready_i = 1'b1;
    tick();
    chk("after_stall_valid", inst_valid_o, 0);
    chk("after_stall_req", req_valid_o, 1);
    chk("after_stall_addr", req_addr_o, h_pc + 64'd4);

    // Redirect while waiting for a slow response.
    rsp_delay = 2;
    wait_req("slow_req");
    tick();
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0100;
    tick();
    redirect_valid_i = 1'b0;
    wait_req("redir_req");
    chk("redir_req_addr", req_addr_o, 64'h8000_0100);
    rsp_delay = 0;
    wait_inst("redir_inst");
    chk("redir_inst_pc", pc_o, 64'h8000_0100);
    chk("redir_inst_word", inst_o, 32'hda5a_0113);

    // Redirect in the same cycle as the response.
    tick();
    wait_req("same_req");
    tick();
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0180;
    tick();
    redirect_valid_i = 1'b0;
    chk("same_cycle_req", req_valid_o, 1);
    chk("same_cycle_addr", req_addr_o, 64'h8000_0180);

    // Misaligned redirect produces a fault without touching memory.
    inst_ready_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0102;
    tick();
    redirect_valid_i = 1'b0;
    req_seen = 1'b0;
    for (int k = 0; k < 20 && !inst_valid_o; k++) begin
      if (req_valid_o) req_seen = 1'b1;
      tick();
    end
    chk("mis_no_req", req_seen, 0);
    chk("mis_valid", inst_valid_o, 1);
    chk("mis_err", inst_err_o, 1);
    chk("mis_inst", inst_o, 0);
    chk("mis_pc", pc_o, 64'h8000_0102);

    // Consume the fault while redirecting to a faulting address.
    inst_ready_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = ERR_ADDR;
    tick();
    inst_ready_i = 1'b0; redirect_valid_i = 1'b0;
    wait_inst("accerr_inst");
    chk("accerr_err", inst_err_o, 1);
    chk("accerr_inst_word", inst_o, 0);
    chk("accerr_pc", pc_o, 64'h8000_0200);
    inst_ready_i = 1'b1;
    wait_fetches(3);

    // Reset in the middle of a wait.
    rsp_delay = 3;
    wait_req("prereset_req");
    tick();
    #2 rst_n_i = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    tick(); tick();
    rsp_delay = 0;
    rst_n_i = 1'b1;
    wait_req("postreset_req");
    chk("postreset_addr", req_addr_o, 64'h8000_0000);
    wait_inst("postreset_inst");
    chk("postreset_word", inst_o, 32'h0010_0073);
    wait_fetches(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
